rib_arbiter: RTL and testbench

// - Shares the single RIB slave-side bus among NUM_M masters (m0 = core load/store, m1 = JTAG, m2/m3 = debug/DMA).
// - Round-robin arbitration with the grant locked until the slave acks, or until a watchdog timeout fires.
// - Drives hold_flag_o into ctrl's hold_flag_rib_i so the core stalls its PC while its bus access is pending.

---
 rtl/rib_arbiter_pkg.sv | 8 +
 rtl/rib_arbiter_if.sv | 19 +
 rtl/rib_arbiter_rr_pick.sv | 18 +
 rtl/rib_arbiter.sv | 70 +++++++
 tb/tb_rib_arbiter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/rib_arbiter_pkg.sv
// rib_arbiter_pkg: shared encodings and default parameters for the RIB arbiter
package rib_arbiter_pkg;
   typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;
   localparam int RIB_NUM_M   = 4;
   localparam int RIB_ADDR_W  = 32;
   localparam int RIB_DATA_W  = 32;
   localparam int RIB_TIMEOUT = 255;
endpackage

// File: rtl/rib_arbiter_if.sv
// rib_arbiter_if: master-side and slave-side RIB bus signals around the arbiter
interface rib_arbiter_if
   import rib_arbiter_pkg::*;
   #(parameter int NUM_M = RIB_NUM_M, parameter int ADDR_W = RIB_ADDR_W, parameter int DATA_W = RIB_DATA_W);
   logic [NUM_M-1:0]        m_req, m_we, m_ack, m_err, grant;
   logic [NUM_M*ADDR_W-1:0] m_addr;
   logic [NUM_M*DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0]       m_rdata, s_wdata, s_rdata;
   logic [ADDR_W-1:0]       s_addr;
   logic                    s_req, s_we, s_ack, hold_flag;
   modport master (
      output m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
      input  m_rdata, m_ack, m_err, grant, s_req, s_we, s_addr, s_wdata, hold_flag
   );
   modport slave (
      input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
      output m_rdata, m_ack, m_err, grant, s_req, s_we, s_addr, s_wdata, hold_flag
   );
endinterface

// File: rtl/rib_arbiter_rr_pick.sv
// rib_arbiter_rr_pick: one-hot pick of the first requester at or after ptr, wrapping
module rib_arbiter_rr_pick
   import rib_arbiter_pkg::*;
   #(parameter int NUM_M = RIB_NUM_M, localparam int PW = $clog2(NUM_M))
   (
      input  logic [NUM_M-1:0] req,
      input  logic [PW-1:0]    ptr,
      output logic [NUM_M-1:0] gnt
   );
   logic [2*NUM_M-1:0] dbl, dgnt;
   logic [NUM_M-1:0]   rot, rot_gnt;
   // rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
   assign dbl     = {req, req} >> ptr;
   assign rot     = dbl[NUM_M-1:0];
   assign rot_gnt = rot & -rot;
   assign dgnt    = {rot_gnt, rot_gnt} << ptr;
   assign gnt     = dgnt[2*NUM_M-1:NUM_M];
endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter: round-robin sharing of the RIB slave bus with grant lock and timeout abort
module rib_arbiter
   import rib_arbiter_pkg::*;
   #(
      parameter int NUM_M   = RIB_NUM_M,
      parameter int ADDR_W  = RIB_ADDR_W,
      parameter int DATA_W  = RIB_DATA_W,
      parameter int TIMEOUT = RIB_TIMEOUT
   )
   (
      input logic clk,
      input logic rst,
      rib_arbiter_if.slave bus
   );
   localparam int PW = $clog2(NUM_M);
   localparam int CW = $clog2(TIMEOUT + 1);
   arb_state_t       state;
   logic [PW-1:0]    ptr, own, pick_idx, nxt;
   logic [CW-1:0]    cnt;
   logic [NUM_M-1:0] pick;
   logic             done;
   rib_arbiter_rr_pick #(.NUM_M(NUM_M)) u_pick (.req(bus.m_req), .ptr(ptr), .gnt(pick));
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_M; i++) if (pick[i]) pick_idx = PW'(i);
   end
   assign nxt           = (own == PW'(NUM_M - 1)) ? '0 : own + 1'b1;
   assign done          = bus.s_ack || cnt == CW'(TIMEOUT - 1);
   assign bus.m_rdata   = bus.s_rdata;
   assign bus.m_ack     = (bus.s_ack && !rst) ? bus.grant : '0;
   assign bus.hold_flag = bus.m_req[0] & ~bus.m_ack[0] & ~rst;
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ARB_IDLE;
         bus.grant   <= '0;
         bus.s_req   <= 1'b0;
         bus.s_we    <= 1'b0;
         bus.s_addr  <= '0;
         bus.s_wdata <= '0;
         bus.m_err   <= '0;
         cnt         <= '0;
         ptr         <= '0;
         own         <= '0;
      end else begin
         bus.m_err <= '0;
         if (state == ARB_IDLE) begin
            if (|bus.m_req) begin
               state       <= ARB_BUSY;
               bus.grant   <= pick;
               own         <= pick_idx;
               bus.s_req   <= 1'b1;
               bus.s_we    <= |(bus.m_we & pick);
               bus.s_addr  <= bus.m_addr[pick_idx*ADDR_W +: ADDR_W];
               bus.s_wdata <= bus.m_wdata[pick_idx*DATA_W +: DATA_W];
               cnt         <= '0;
            end
         end else begin
            cnt <= cnt + 1'b1;
            if (done) begin
               state     <= ARB_IDLE;
               bus.grant <= '0;
               bus.s_req <= 1'b0;
               ptr       <= nxt;
               // ack takes priority over a coincident timeout
               bus.m_err <= bus.s_ack ? '0 : bus.grant;
            end
         end
      end
   end
endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: directed scenarios for rib_arbiter with hand-computed expectations
module tb_rib_arbiter;
   import rib_arbiter_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vecs = 0;
   int   errs = 0;
   rib_arbiter_if #(.NUM_M(4), .ADDR_W(32), .DATA_W(32)) bus ();
   rib_arbiter #(.NUM_M(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic test_reset;
      rst = 1'b1;
      bus.m_req = 4'b0001; bus.m_we = '0; bus.m_addr = '0; bus.m_wdata = '0;
      bus.s_ack = 1'b1; bus.s_rdata = '0;
      @(negedge clk); @(negedge clk);
      vecs++; if (bus.grant !== 4'b0000) begin errs++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
      vecs++; if (bus.s_req !== 1'b0) begin errs++; $display("FAIL reset_s_req got %b want 0", bus.s_req); end
      vecs++; if (bus.s_addr !== 32'h0) begin errs++; $display("FAIL reset_s_addr got %h want 0", bus.s_addr); end
      vecs++; if (bus.m_err !== 4'b0000) begin errs++; $display("FAIL reset_m_err got %b want 0000", bus.m_err); end
      vecs++; if (bus.hold_flag !== 1'b0) begin errs++; $display("FAIL reset_hold got %b want 0", bus.hold_flag); end
      vecs++; if (bus.m_ack !== 4'b0000) begin errs++; $display("FAIL reset_m_ack got %b want 0000", bus.m_ack); end
      rst = 1'b0; bus.m_req = '0; bus.s_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_read;
      bus.m_req = 4'b0001; bus.m_addr[31:0] = 32'h1000_0004; bus.m_we = '0;
      #1;
      vecs++; if (bus.hold_flag !== 1'b1) begin errs++; $display("FAIL sr_hold_req got %b want 1", bus.hold_flag); end
      vecs++; if (bus.s_req !== 1'b0) begin errs++; $display("FAIL sr_s_req_early got %b want 0", bus.s_req); end
      @(negedge clk);
      vecs++; if (bus.s_req !== 1'b1) begin errs++; $display("FAIL sr_s_req got %b want 1", bus.s_req); end
      vecs++; if (bus.grant !== 4'b0001) begin errs++; $display("FAIL sr_grant got %b want 0001", bus.grant); end
      vecs++; if (bus.s_addr !== 32'h1000_0004) begin errs++; $display("FAIL sr_s_addr got %h want 10000004", bus.s_addr); end
      vecs++; if (bus.s_we !== 1'b0) begin errs++; $display("FAIL sr_s_we got %b want 0", bus.s_we); end
      for (int i = 0; i < 3; i++) begin
         vecs++; if (bus.hold_flag !== 1'b1) begin errs++; $display("FAIL sr_hold_wait%0d got %b want 1", i, bus.hold_flag); end
         @(negedge clk);
      end
      bus.s_ack = 1'b1; bus.s_rdata = 32'hDEAD_BEEF;
      #1;
      vecs++; if (bus.m_ack !== 4'b0001) begin errs++; $display("FAIL sr_m_ack got %b want 0001", bus.m_ack); end
      vecs++; if (bus.m_rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL sr_rdata got %h want deadbeef", bus.m_rdata); end
      vecs++; if (bus.hold_flag !== 1'b0) begin errs++; $display("FAIL sr_hold_ack got %b want 0", bus.hold_flag); end
      bus.m_req = '0;
      @(negedge clk);
      bus.s_ack = 1'b0;
      vecs++; if (bus.s_req !== 1'b0 || bus.grant !== 4'b0000) begin errs++; $display("FAIL sr_release got s_req=%b grant=%b want 0 0000", bus.s_req, bus.grant); end
      bus.s_ack = 1'b1;
      #1;
      vecs++; if (bus.m_ack !== 4'b0000) begin errs++; $display("FAIL idle_ack got %b want 0000", bus.m_ack); end
      @(negedge clk);
      bus.s_ack = 1'b0;
      vecs++; if (bus.grant !== 4'b0000) begin errs++; $display("FAIL idle_ack_grant got %b want 0000", bus.grant); end
   endtask

   task automatic test_round_robin;
      logic [3:0] exp;
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) bus.m_addr[i*32 +: 32] = 32'h100 * (i + 1);
      bus.m_req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         exp = 4'b0001 << (i % 4);
         @(negedge clk);
         vecs++; if (bus.grant !== exp) begin errs++; $display("FAIL rr_grant%0d got %b want %b", i, bus.grant, exp); end
         vecs++; if (bus.s_addr !== 32'h100 * ((i % 4) + 1)) begin errs++; $display("FAIL rr_addr%0d got %h want %h", i, bus.s_addr, 32'h100 * ((i % 4) + 1)); end
         bus.s_ack = 1'b1;
         #1;
         vecs++; if (bus.m_ack !== exp) begin errs++; $display("FAIL rr_ack%0d got %b want %b", i, bus.m_ack, exp); end
         @(negedge clk);
         bus.s_ack = 1'b0;
         vecs++; if (bus.grant !== 4'b0000) begin errs++; $display("FAIL rr_bubble%0d got %b want 0000", i, bus.grant); end
      end
      bus.m_req = '0;
      @(negedge clk);
   endtask

   task automatic test_timeout;
      bus.m_req = 4'b0100;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         vecs++; if (bus.grant !== 4'b0100 || bus.m_err !== 4'b0000) begin errs++; $display("FAIL to_busy%0d got grant=%b err=%b want 0100 0000", i, bus.grant, bus.m_err); end
      end
      @(negedge clk);
      vecs++; if (bus.m_err !== 4'b0100) begin errs++; $display("FAIL to_err got %b want 0100", bus.m_err); end
      vecs++; if (bus.s_req !== 1'b0) begin errs++; $display("FAIL to_s_req got %b want 0", bus.s_req); end
      bus.m_req = '0;
      @(negedge clk);
      vecs++; if (bus.m_err !== 4'b0000) begin errs++; $display("FAIL to_err_pulse got %b want 0000", bus.m_err); end
      bus.m_req = 4'b1111;
      @(negedge clk);
      vecs++; if (bus.grant !== 4'b1000) begin errs++; $display("FAIL to_ptr got %b want 1000", bus.grant); end
      bus.s_ack = 1'b1; bus.m_req = '0;
      @(negedge clk);
      bus.s_ack = 1'b0;
   endtask

   task automatic test_collide;
      bus.m_req = 4'b0010;
      for (int i = 0; i < 8; i++) @(negedge clk);
      bus.s_ack = 1'b1;
      #1;
      vecs++; if (bus.m_ack !== 4'b0010) begin errs++; $display("FAIL col_ack got %b want 0010", bus.m_ack); end
      @(negedge clk);
      bus.s_ack = 1'b0; bus.m_req = '0;
      vecs++; if (bus.m_err !== 4'b0000) begin errs++; $display("FAIL col_err got %b want 0000", bus.m_err); end
      vecs++; if (bus.grant !== 4'b0000 || bus.s_req !== 1'b0) begin errs++; $display("FAIL col_idle got grant=%b s_req=%b want 0000 0", bus.grant, bus.s_req); end
   endtask

   task automatic test_reset_mid;
      bus.m_req = 4'b0010; bus.m_addr[63:32] = 32'hABCD_0001;
      @(negedge clk);
      vecs++; if (bus.grant !== 4'b0010) begin errs++; $display("FAIL rm_grant got %b want 0010", bus.grant); end
      rst = 1'b1;
      @(negedge clk);
      vecs++; if (bus.grant !== 4'b0000 || bus.s_req !== 1'b0 || bus.m_err !== 4'b0000) begin errs++; $display("FAIL rm_clear got grant=%b s_req=%b err=%b want 0000 0 0000", bus.grant, bus.s_req, bus.m_err); end
      vecs++; if (bus.s_addr !== 32'h0) begin errs++; $display("FAIL rm_s_addr got %h want 0", bus.s_addr); end
      rst = 1'b0; bus.m_req = 4'b0011;
      @(negedge clk);
      vecs++; if (bus.grant !== 4'b0001) begin errs++; $display("FAIL rm_regrant got %b want 0001", bus.grant); end
      bus.s_ack = 1'b1; bus.m_req = '0;
      @(negedge clk);
      bus.s_ack = 1'b0;
   endtask

   task automatic test_withdraw;
      bus.m_req = 4'b1000; bus.m_we = 4'b1000;
      bus.m_addr[127:96] = 32'hCAFE_0003; bus.m_wdata[127:96] = 32'h5555_AAAA;
      @(negedge clk);
      vecs++; if (bus.grant !== 4'b1000) begin errs++; $display("FAIL wd_grant got %b want 1000", bus.grant); end
      vecs++; if (bus.s_we !== 1'b1 || bus.s_wdata !== 32'h5555_AAAA) begin errs++; $display("FAIL wd_write got we=%b wdata=%h want 1 5555aaaa", bus.s_we, bus.s_wdata); end
      bus.m_req = '0; bus.m_addr[127:96] = 32'h0000_FFFF;
      @(negedge clk);
      vecs++; if (bus.s_addr !== 32'hCAFE_0003) begin errs++; $display("FAIL wd_addr1 got %h want cafe0003", bus.s_addr); end
      @(negedge clk);
      bus.s_ack = 1'b1;
      #1;
      vecs++; if (bus.m_ack !== 4'b1000) begin errs++; $display("FAIL wd_ack got %b want 1000", bus.m_ack); end
      vecs++; if (bus.s_addr !== 32'hCAFE_0003) begin errs++; $display("FAIL wd_addr2 got %h want cafe0003", bus.s_addr); end
      @(negedge clk);
      bus.s_ack = 1'b0;
      vecs++; if (bus.grant !== 4'b0000) begin errs++; $display("FAIL wd_idle got %b want 0000", bus.grant); end
   endtask

   initial begin
      test_reset;
      test_single_read;
      test_round_robin;
      test_timeout;
      test_collide;
      test_reset_mid;
      test_withdraw;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
